// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [1:0]  BUF_DEPTH        = 2'd2;

  typedef enum logic [1:0] {
    IF_REQ  = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_buf.sv
// rtl/fetch_stage_buf.sv - 2-entry instruction queue of {pc, instr}; flush dominates push
module fetch_stage_buf
  import fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t slot0_q, slot0_d;
  fetch_entry_t slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;
  logic         do_pop, do_push;

  always_comb begin
    do_pop  = pop_i && (count_q != 2'd0);
    do_push = push_i && ((count_q < BUF_DEPTH) || do_pop);
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      // Pop shifts first, so a simultaneous push lands behind the surviving entry.
      if (do_pop) begin
        slot0_d = slot1_q;
        count_d = count_d - 2'd1;
      end
      if (do_push) begin
        if (count_d == 2'd0) slot0_d = push_data_i;
        else                 slot1_d = push_data_i;
        count_d = count_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = slot0_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, single-outstanding fetch FSM and decode-facing outputs
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ready,
  input  logic        inst_rvalid,
  input  logic [31:0] inst_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stallD,
  output logic        validD,
  output logic [31:0] instrD,
  output logic [5:0]  opD,
  output logic [5:0]  functD,
  output logic [31:0] pcD,
  output logic [31:0] pcplus4D
);

  if_state_e    state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         started_q;
  logic         handshake, push, pop;
  logic [1:0]   count;
  fetch_entry_t head, push_data;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_req  = 1'b0;
    handshake = 1'b0;
    push      = 1'b0;
    unique case (state_q)
      IF_REQ: begin
        inst_req  = started_q && (count < BUF_DEPTH);
        handshake = inst_req && inst_ready;
        if (handshake) begin
          pc_d    = pc_q + 32'd4;
          state_d = IF_WAIT;
        end
      end
      IF_WAIT: if (inst_rvalid) begin
        push    = 1'b1;
        state_d = IF_REQ;
      end
      IF_DROP: if (inst_rvalid) state_d = IF_REQ;
      default: state_d = IF_REQ;
    endcase
    // A response arriving with the redirect retires the outstanding request, so no DROP is needed.
    if (redirect_valid) begin
      pc_d = redirect_pc & 32'hFFFF_FFFC;
      push = 1'b0;
      if (state_q == IF_REQ) state_d = handshake ? IF_DROP : IF_REQ;
      else                   state_d = inst_rvalid ? IF_REQ : IF_DROP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IF_REQ;
      pc_q      <= RESET_PC;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      started_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(inst_rvalid && state_q == IF_REQ)) else $error("rvalid with no outstanding request");
  end

  assign push_data.pc    = pc_q - 32'd4;
  assign push_data.instr = inst_rdata;
  assign pop             = validD && !stallD;

  fetch_stage_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .flush_i    (redirect_valid),
    .count_o    (count),
    .head_o     (head)
  );

  assign inst_addr = pc_q;
  assign validD    = (count != 2'd0);
  assign instrD    = validD ? head.instr : NOP_INST;
  assign pcD       = validD ? head.pc : 32'h0;
  assign pcplus4D  = validD ? head.pc + 32'd4 : 32'h0;
  assign opD       = instrD[31:26];
  assign functD    = instrD[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed scoreboard bench for fetch_stage
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk, rst;
  logic        inst_req, inst_ready, inst_rvalid;
  logic [31:0] inst_addr, inst_rdata;
  logic        redirect_valid, stallD, validD;
  logic [31:0] redirect_pc, instrD, pcD, pcplus4D;
  logic [5:0]  opD, functD;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ready(inst_ready),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stallD(stallD),
    .validD(validD), .instrD(instrD), .opD(opD), .functD(functD),
    .pcD(pcD), .pcplus4D(pcplus4D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  ent_t        sb[$];
  logic [31:0] exp_pc;
  bit          pend, pend_stale;
  logic [31:0] pend_addr;
  int          pend_wait, resp_extra, hs_count;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"},    {31'b0, inst_req}, 32'h0);
    chk({tag, "_valid"},  {31'b0, validD},   32'h0);
    chk({tag, "_instr"},  instrD,            32'h0);
    chk({tag, "_op"},     {26'b0, opD},      32'h0);
    chk({tag, "_funct"},  {26'b0, functD},   32'h0);
    chk({tag, "_pc"},     pcD,               32'h0);
    chk({tag, "_pc4"},    pcplus4D,          32'h0);
  endtask

  // One clock: check DUT against the model at negedge, then drive inputs for the next posedge.
  task automatic cycle(input bit rdy, input bit stl, input bit redir, input logic [31:0] rpc);
    ent_t        e;
    logic [31:0] e_instr, e_pc, e_p4, old_pc;
    bit          e_valid, deliver, hs;
    @(negedge clk);
    e_valid = (sb.size() != 0);
    if (e_valid) begin
      e = sb[0];
      e_instr = e.instr; e_pc = e.pc; e_p4 = e.pc + 32'd4;
    end else begin
      e_instr = 32'h0; e_pc = 32'h0; e_p4 = 32'h0;
    end
    chk("validD",   {31'b0, validD},  {31'b0, e_valid});
    chk("instrD",   instrD,           e_instr);
    chk("opD",      {26'b0, opD},     {26'b0, e_instr[31:26]});
    chk("functD",   {26'b0, functD},  {26'b0, e_instr[5:0]});
    chk("pcD",      pcD,              e_pc);
    chk("pcplus4D", pcplus4D,         e_p4);
    if (inst_req) chk("inst_addr", inst_addr, exp_pc);

    deliver = 1'b0;
    if (pend) begin
      if (pend_wait == 0) deliver = 1'b1;
      else pend_wait--;
    end
    inst_rvalid = deliver;
    inst_rdata  = deliver ? mem_word(pend_addr) : $urandom;
    hs = inst_req && rdy;
    if (hs) chk("single_outstanding", {31'b0, pend}, 32'h0);
    inst_ready     = rdy;
    stallD         = stl;
    redirect_valid = redir;
    redirect_pc    = rpc;

    old_pc = exp_pc;
    if (redir) begin
      sb.delete();
      exp_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (sb.size() != 0 && !stl) void'(sb.pop_front());
      if (deliver && !pend_stale) begin
        e.pc = pend_addr; e.instr = mem_word(pend_addr);
        sb.push_back(e);
      end
      if (hs) exp_pc = exp_pc + 32'd4;
    end
    if (deliver) pend = 1'b0;
    if (hs) begin
      pend = 1'b1; pend_addr = old_pc; pend_wait = resp_extra; pend_stale = redir;
      hs_count++;
    end else if (redir && pend) begin
      pend_stale = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int hs0;
    rst = 1'b1;
    inst_ready = 1'b0; inst_rvalid = 1'b0; inst_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; stallD = 1'b0;
    pend = 1'b0; pend_stale = 1'b0; pend_addr = 32'h0; pend_wait = 0;
    resp_extra = 0; hs_count = 0; exp_pc = RST_PC;

    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    #1 chk("release_req", {31'b0, inst_req}, 32'h0);

    // 1: streaming fetch from RESET_PC
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // 2: stall fills the queue, request drops, then drain
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("stall_req_drop", {31'b0, inst_req}, 32'h0);
    chk("stall_valid",    {31'b0, validD},   32'h1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // 3: redirect while waiting on a slow response
    resp_extra = 2;
    for (int i = 0; i < 20 && !pend; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t3_reached_wait", {31'b0, pend}, 32'h1);
    cycle(1'b1, 1'b0, 1'b1, 32'h0040_0020);
    resp_extra = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      if (validD) break;
    end
    chk("t3_first_pc",  pcD,      32'h0040_0020);
    chk("t3_first_pc4", pcplus4D, 32'h0040_0024);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // 4: redirect coinciding with rvalid and a pop
    for (int i = 0; i < 20 && !(pend && pend_wait == 0 && sb.size() != 0); i++)
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t4_setup", {31'b0, pend}, 32'h1);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_1000);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t4_flushed", {31'b0, validD}, 32'h0);

    // 5: request held under ready=0, redirect mid-hold, single handshake
    hs0 = hs_count;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      chk("t5_hold_req", {31'b0, inst_req}, 32'h1);
    end
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_2000);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      chk("t5_hold_req2", {31'b0, inst_req}, 32'h1);
      chk("t5_hold_addr", inst_addr, 32'h0000_2000);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t5_one_handshake", hs_count - hs0, 32'd1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // PC wrap and ignored low redirect bits
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFB);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      if (pcD == 32'hFFFF_FFFC) break;
    end
    chk("wrap_pc",  pcD,      32'hFFFF_FFFC);
    chk("wrap_pc4", pcplus4D, 32'h0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // 6: asynchronous reset with a queued word and a request outstanding
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    resp_extra = 3;
    for (int i = 0; i < 30 && !(sb.size() == 1 && pend); i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6_setup", {31'b0, pend}, 32'h1);
    @(posedge clk);
    #2 chk("t6_pre_valid", {31'b0, validD}, 32'h1);
    rst = 1'b1;
    #1 chk_idle_outputs("t6_async");
    sb.delete(); pend = 1'b0; pend_stale = 1'b0; resp_extra = 0; exp_pc = RST_PC;
    inst_ready = 1'b0; inst_rvalid = 1'b0; redirect_valid = 1'b0; stallD = 1'b0;
    @(negedge clk);
    chk_idle_outputs("t6_held");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
